i2s_rx_capture: RTL and testbench

I2S receiver for the DECA audio codec's ADC path: takes the codec's serial DOUT stream plus bit/word clocks and delivers parallel left/right sample pairs. It is the receive-direction counterpart of the existing I2S DAC transmitter and sits beside it in the board top, driven by the same 50 MHz board clock. All codec-side signals are oversampled; no logic is clocked by BCLK.

---
 rtl/i2s_rx_capture.sv | 136 +++++++++++++
 tb/tb_i2s_rx_capture.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_capture.sv
// I2S receiver: oversamples codec BCLK/LRCK/DIN on the system clock and presents
// left/right sample pairs with a valid/ready handshake and an overrun pulse.
//
// state | meaning
// SYNC  | waiting for a 1->0 LRCK change (start of a left word); bits discarded
// RUN   | framing locked; words captured into l_hold and the output pair
module i2s_rx_capture #(
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              iCLK_50,
    input  logic              iRESET_n,
    input  logic              iBCLK,
    input  logic              iLRCK,
    input  logic              iDIN,
    output logic [DATA_W-1:0] oL_data,
    output logic [DATA_W-1:0] oR_data,
    output logic              oValid,
    input  logic              iReady,
    output logic              oOverrun,
    output logic              oLocked
);

    typedef enum logic {ST_SYNC, ST_RUN} state_t;

    localparam logic [15:0]       TO_LOAD = 16'(TIMEOUT_CYC);
    localparam logic [DATA_W-1:0] MSB_ONE = {1'b1, {(DATA_W-1){1'b0}}};

    state_t            state_q, state_d;
    logic [2:0]        bclk_sync;
    logic [1:0]        lrck_sync, din_sync;
    logic              bclk_rise, lrck_s, din_s, lrck_q;
    logic              lrck_fall, lrck_rise, timeout;
    logic              left_done, pair_done;
    logic [5:0]        bit_cnt;
    logic [15:0]       to_cnt;
    logic [DATA_W-1:0] shift_q, word_cur, l_hold;

    assign bclk_rise = bclk_sync[1] & ~bclk_sync[2];
    assign lrck_s    = lrck_sync[1];
    assign din_s     = din_sync[1];
    assign lrck_fall = bclk_rise & lrck_q & ~lrck_s;
    assign lrck_rise = bclk_rise & ~lrck_q & lrck_s;
    assign timeout   = ~bclk_rise && (to_cnt == 16'd1);
    assign oLocked   = (state_q == ST_RUN);

    // Shifting past the MSB position yields zero, so bits beyond DATA_W drop out.
    assign word_cur  = din_s ? (shift_q | (MSB_ONE >> bit_cnt)) : shift_q;

    always_ff @(posedge iCLK_50) begin
        if (!iRESET_n) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        left_done = 1'b0;
        pair_done = 1'b0;
        case (state_q)
            ST_SYNC: begin
                if (lrck_fall) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (timeout) begin
                    state_d = ST_SYNC;
                end else if (lrck_rise) begin
                    left_done = 1'b1;
                end else if (lrck_fall) begin
                    pair_done = 1'b1;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    always_ff @(posedge iCLK_50) begin
        if (!iRESET_n) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            din_sync  <= '0;
            lrck_q    <= 1'b0;
            bit_cnt   <= '0;
            to_cnt    <= '0;
            shift_q   <= '0;
            l_hold    <= '0;
            oL_data   <= '0;
            oR_data   <= '0;
            oValid    <= 1'b0;
            oOverrun  <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[1:0], iBCLK};
            lrck_sync <= {lrck_sync[0], iLRCK};
            din_sync  <= {din_sync[0], iDIN};

            if (bclk_rise) begin
                to_cnt <= TO_LOAD;
                lrck_q <= lrck_s;
            end else if (to_cnt != 16'd0) begin
                to_cnt <= to_cnt - 16'd1;
            end

            // A word boundary or SYNC state restarts the word from the MSB.
            if (timeout) begin
                bit_cnt <= '0;
                shift_q <= '0;
            end else if (bclk_rise) begin
                if ((lrck_s != lrck_q) || (state_q == ST_SYNC)) begin
                    bit_cnt <= '0;
                    shift_q <= '0;
                end else begin
                    shift_q <= word_cur;
                    if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
                end
            end

            if (left_done) l_hold <= word_cur;

            oOverrun <= 1'b0;
            if (pair_done) begin
                if (!oValid || iReady) begin
                    oL_data <= l_hold;
                    oR_data <= word_cur;
                    oValid  <= 1'b1;
                end else begin
                    oOverrun <= 1'b1;
                end
            end else if (oValid && iReady) begin
                oValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_capture.sv
// Scoreboard bench for i2s_rx_capture: serial I2S frames in, expected pairs queued
// from a slot-level model, popped by monitors on each output handshake.
module tb_i2s_rx_capture;

    logic        clk = 1'b0;
    logic        rst_n, bclk, lrck, din, ready, ready2, sel2;
    logic        bclk1, bclk2;
    logic [15:0] l1, r1;
    logic [23:0] l2, r2;
    logic        v1, v2, ovr1, ovr2, lk1, lk2;

    int          total = 0;
    int          bad = 0;
    int          ovr_seen = 0;
    int          exp_ovr = 0;
    logic [63:0] q1[$];
    logic [63:0] q2[$];

    always #10 clk = ~clk;

    assign bclk1 = sel2 ? 1'b0 : bclk;
    assign bclk2 = sel2 ? bclk : 1'b0;

    i2s_rx_capture #(.DATA_W(16), .TIMEOUT_CYC(1023)) dut1 (
        .iCLK_50(clk), .iRESET_n(rst_n), .iBCLK(bclk1), .iLRCK(lrck), .iDIN(din),
        .oL_data(l1), .oR_data(r1), .oValid(v1), .iReady(ready),
        .oOverrun(ovr1), .oLocked(lk1));

    i2s_rx_capture #(.DATA_W(24), .TIMEOUT_CYC(1023)) dut2 (
        .iCLK_50(clk), .iRESET_n(rst_n), .iBCLK(bclk2), .iLRCK(lrck), .iDIN(din),
        .oL_data(l2), .oR_data(r2), .oValid(v2), .iReady(ready2),
        .oOverrun(ovr2), .oLocked(lk2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Sample captured from a left-aligned s-bit slot by a dw-bit receiver.
    function automatic logic [31:0] capt(input int dw, input int s, input logic [31:0] slot);
        logic [63:0] v;
        logic [63:0] mask;
        v = {32'b0, slot};
        if (s >= dw) v = v >> (s - dw);
        else         v = v << (dw - s);
        mask = (64'd1 << dw) - 64'd1;
        v = v & mask;
        return v[31:0];
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (ovr1) ovr_seen++;
            if (v1 && ready) begin
                if (q1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL pair1_unexpected: got %h/%h expected none", l1, r1);
                end else begin
                    logic [63:0] e;
                    e = q1.pop_front();
                    chk("pair1_left", {16'b0, l1}, e[63:32]);
                    chk("pair1_right", {16'b0, r1}, e[31:0]);
                end
            end
            if (v2 && ready2) begin
                if (q2.size() == 0) begin
                    total++; bad++;
                    $display("FAIL pair2_unexpected: got %h/%h expected none", l2, r2);
                end else begin
                    logic [63:0] e;
                    e = q2.pop_front();
                    chk("pair2_left", {8'b0, l2}, e[63:32]);
                    chk("pair2_right", {8'b0, r2}, e[31:0]);
                end
            end
        end
    end

    // One BCLK period: data/word clock change with the falling edge, sampled on the rise.
    task automatic send_rise(input logic l, input logic d, input bit pulse);
        bclk = 1'b0; lrck = l; din = d;
        repeat (8) @(posedge clk);
        #1 bclk = 1'b1;
        if (pulse) begin
            repeat (2) @(posedge clk);
            #1 ready = 1'b1;
            @(posedge clk);
            #1 ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
        end else begin
            repeat (8) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [31:0] ls, input logic [31:0] rs, input int s, input bit pulse);
        for (int i = s - 1; i >= 1; i--) send_rise(1'b0, ls[i], 1'b0);
        send_rise(1'b1, ls[0], 1'b0);
        for (int i = s - 1; i >= 1; i--) send_rise(1'b1, rs[i], 1'b0);
        send_rise(1'b0, rs[0], pulse);
    endtask

    task automatic lock_seq();
        for (int i = 0; i < 12; i++) send_rise(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        send_rise(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic frame16(input logic [31:0] ls, input logic [31:0] rs, input bit push);
        if (push) q1.push_back({capt(16, 32, ls), capt(16, 32, rs)});
        send_frame(ls, rs, 32, 1'b0);
    endtask

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        rst_n = 1'b0; bclk = 1'b0; lrck = 1'b1; din = 1'b0;
        ready = 1'b1; ready2 = 1'b1; sel2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_l", {16'b0, l1}, 32'h0);
        chk("rst_r", {16'b0, r1}, 32'h0);
        chk("rst_valid", {31'b0, v1}, 32'h0);
        chk("rst_overrun", {31'b0, ovr1}, 32'h0);
        chk("rst_locked", {31'b0, lk1}, 32'h0);
        rst_n = 1'b1;

        // Basic capture
        lock_seq();
        chk("lock_locked", {31'b0, lk1}, 32'h1);
        chk("lock_no_valid", {31'b0, v1}, 32'h0);
        frame16({16'h8001, 16'h5a5a}, {16'h7ffe, 16'ha5a5}, 1'b1);
        for (int k = 0; k < 6; k++) frame16($urandom(), $urandom(), 1'b1);
        repeat (4) @(posedge clk);
        #1 chk("basic_drained", q1.size(), 32'd0);

        // Backpressure: second pair discarded
        ready = 1'b0;
        frame16({16'h1111, 16'h0}, {16'h2222, 16'h0}, 1'b1);
        frame16({16'h3333, 16'hffff}, {16'h4444, 16'hffff}, 1'b0);
        exp_ovr++;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_l", {16'b0, l1}, 32'h1111);
        chk("bp_r", {16'b0, r1}, 32'h2222);
        chk("bp_valid", {31'b0, v1}, 32'h1);
        chk("bp_overruns", ovr_seen, exp_ovr);
        ready = 1'b1;
        @(posedge clk);
        #1 chk("bp_valid_clear", {31'b0, v1}, 32'h0);

        // Handshake in the completion cycle
        ready = 1'b0;
        frame16({16'haaaa, 16'h1234}, {16'hbbbb, 16'h4321}, 1'b1);
        q1.push_back({32'h5555, 32'h6666});
        send_frame({16'h5555, 16'h0f0f}, {16'h6666, 16'hf0f0}, 32, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("sim_l", {16'b0, l1}, 32'h5555);
        chk("sim_r", {16'b0, r1}, 32'h6666);
        chk("sim_valid", {31'b0, v1}, 32'h1);
        chk("sim_overruns", ovr_seen, exp_ovr);
        ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Timeout mid right word
        a = $urandom(); b = $urandom();
        for (int i = 31; i >= 1; i--) send_rise(1'b0, a[i], 1'b0);
        send_rise(1'b1, a[0], 1'b0);
        for (int i = 31; i >= 22; i--) send_rise(1'b1, b[i], 1'b0);
        repeat (900) @(posedge clk);
        #1 chk("to_still_locked", {31'b0, lk1}, 32'h1);
        repeat (200) @(posedge clk);
        #1 chk("to_unlocked", {31'b0, lk1}, 32'h0);
        for (int i = 0; i < 5; i++) send_rise(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        chk("to_no_relock", {31'b0, lk1}, 32'h0);
        send_rise(1'b0, 1'b1, 1'b0);
        chk("to_relock", {31'b0, lk1}, 32'h1);
        frame16($urandom(), $urandom(), 1'b1);
        for (int k = 0; k < 2; k++) frame16($urandom(), $urandom(), 1'b1);

        // Reset while a pair is held
        ready = 1'b0;
        frame16($urandom(), $urandom(), 1'b0);
        repeat (3) @(posedge clk);
        #1 chk("rr_valid_before", {31'b0, v1}, 32'h1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rr_l", {16'b0, l1}, 32'h0);
        chk("rr_r", {16'b0, r1}, 32'h0);
        chk("rr_valid", {31'b0, v1}, 32'h0);
        chk("rr_locked", {31'b0, lk1}, 32'h0);
        ready = 1'b1;
        lock_seq();
        frame16({16'h8001, 16'h0}, {16'h7ffe, 16'h0}, 1'b1);
        for (int k = 0; k < 3; k++) frame16($urandom(), $urandom(), 1'b1);
        repeat (4) @(posedge clk);
        #1 chk("rr_drained", q1.size(), 32'd0);

        // 24-bit receiver fed 16-bit slots
        bclk = 1'b0;
        @(posedge clk);
        #1 sel2 = 1'b1;
        lock_seq();
        chk("short_locked", {31'b0, lk2}, 32'h1);
        for (int k = 0; k < 5; k++) begin
            a = (k == 0) ? 32'h1234 : 32'($urandom_range(0, 65535));
            b = 32'($urandom_range(0, 65535));
            if (k == 0) q2.push_back({32'h123400, capt(24, 16, b)});
            else        q2.push_back({capt(24, 16, a), capt(24, 16, b)});
            send_frame(a, b, 16, 1'b0);
        end
        repeat (6) @(posedge clk);
        #1;
        chk("short_drained", q2.size(), 32'd0);
        chk("final_q1_empty", q1.size(), 32'd0);
        chk("final_overruns", ovr_seen, exp_ovr);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
